// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin packet arbiter in front of sendController.
// Each granted source packet is framed as header {seq,id}, payload bytes
// and an XOR trailer, and handed to sendController one byte at a time.
module tx_frame_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAXLEN    = 64,
    parameter int TXTIMEOUT = 255
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [NREQ-1:0]   src_valid,
    input  logic [8*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]   src_last,
    output logic [NREQ-1:0]   src_ready,
    output logic [NREQ-1:0]   grant,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              overrun,
    output logic              tx_err
);
    localparam int LENW = $clog2(MAXLEN + 1);
    localparam logic [LENW-1:0] LEN_MAX = LENW'(MAXLEN);
    localparam logic [7:0]      TO_LAST = 8'(TXTIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_TRL} state_t;
    // TX_WAIT means no byte is queued for sendController.
    typedef enum logic [1:0] {TX_WAIT, TX_ARM, TX_BUSY, TX_DONE} tx_state_t;

    state_t          state_q, state_d;
    tx_state_t       tx_state_q, tx_state_d;
    logic [3:0]      id_q, id_d;
    logic [3:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0]      seq_q, seq_d;
    logic [7:0]      acc_q, acc_d;
    logic [LENW-1:0] len_q, len_d;
    logic            last_q, last_d;
    logic [7:0]      to_cnt_q, to_cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            transmit_q, transmit_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [NREQ-1:0] src_ready_q, src_ready_d;
    logic            overrun_q, overrun_d;
    logic            tx_err_q, tx_err_d;

    // Sources widened to the 16-source maximum so a 4-bit id indexes them directly.
    logic [15:0]  valid_ext;
    logic [15:0]  last_ext;
    logic [127:0] data_ext;
    logic [7:0]   cur_data;
    logic         arb_found;
    logic [3:0]   arb_winner;
    logic [4:0]   arb_idx;
    logic         byte_done;

    assign valid_ext = 16'(src_valid);
    assign last_ext  = 16'(src_last);
    assign data_ext  = 128'(src_data);
    assign cur_data  = data_ext[{id_q, 3'b000} +: 8];

    // Round-robin search: first valid source at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = 5'(rr_ptr_q) + 5'(k);
            if (arb_idx >= 5'(NREQ)) begin
                arb_idx = arb_idx - 5'(NREQ);
            end
            if (!arb_found && valid_ext[arb_idx[3:0]]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx[3:0];
            end
        end
    end

    // Next-state logic: byte send handshake first, then the frame sequencer that consumes byte_done.
    always_comb begin
        state_d     = state_q;
        tx_state_d  = tx_state_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        seq_d       = seq_q;
        acc_d       = acc_q;
        len_d       = len_q;
        last_d      = last_q;
        to_cnt_d    = to_cnt_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        tx_byte_d   = tx_byte_q;
        tx_err_d    = tx_err_q;
        transmit_d  = 1'b0;
        src_ready_d = '0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;

        unique case (tx_state_q)
            TX_ARM: begin
                // A busy sendController holds off the pulse.
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    to_cnt_d   = '0;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (is_transmitting) begin
                    tx_state_d = TX_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    // No response: flag it and move on as if the byte went out.
                    tx_err_d   = 1'b1;
                    byte_done  = 1'b1;
                    tx_state_d = TX_WAIT;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            TX_DONE: begin
                if (!is_transmitting) begin
                    byte_done  = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    id_d   = arb_winner;
                    busy_d = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        grant_d[i] = (arb_winner == 4'(i));
                    end
                    tx_byte_d  = {seq_q, arb_winner};
                    acc_d      = {seq_q, arb_winner};
                    tx_state_d = TX_ARM;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (byte_done) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (tx_state_q == TX_WAIT) begin
                    if (valid_ext[id_q]) begin
                        for (int i = 0; i < NREQ; i++) begin
                            src_ready_d[i] = (id_q == 4'(i));
                        end
                        tx_byte_d  = cur_data;
                        acc_d      = acc_q ^ cur_data;
                        len_d      = len_q + 1'b1;
                        last_d     = last_ext[id_q];
                        tx_state_d = TX_ARM;
                    end
                end else if (byte_done) begin
                    if (last_q || (len_q == LEN_MAX)) begin
                        // Closing without last can only mean the length cap was hit.
                        overrun_d  = !last_q;
                        tx_byte_d  = acc_q;
                        tx_state_d = TX_ARM;
                        state_d    = ST_TRL;
                    end
                end
            end
            ST_TRL: begin
                if (byte_done) begin
                    seq_d    = seq_q + 4'd1;
                    rr_ptr_d = (id_q == 4'(NREQ - 1)) ? 4'd0 : id_q + 4'd1;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    len_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            tx_state_q  <= TX_WAIT;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            seq_q       <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
            to_cnt_q    <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            transmit_q  <= 1'b0;
            tx_byte_q   <= '0;
            src_ready_q <= '0;
            overrun_q   <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_state_q  <= tx_state_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            seq_q       <= seq_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            last_q      <= last_d;
            to_cnt_q    <= to_cnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            transmit_q  <= transmit_d;
            tx_byte_q   <= tx_byte_d;
            src_ready_q <= src_ready_d;
            overrun_q   <= overrun_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign transmit  = transmit_q;
    assign tx_byte   = tx_byte_q;
    assign src_ready = src_ready_q;
    assign overrun   = overrun_q;
    assign tx_err    = tx_err_q;

endmodule
